// File: rtl/reg_scoreboard_pkg.sv
// Shared types and sizes for the register scoreboard; the register-address width
// and counter width live here so ID, WB and the scoreboard agree on them.
package reg_scoreboard_pkg;

  localparam int REGFILE_ADDRESS_LEN = 4;
  localparam int SCOREBOARD_CNT_LEN  = 2;

  typedef logic [REGFILE_ADDRESS_LEN-1:0] reg_addr_t;

  // One-entry record of the most recent unfrozen issue, used for load-use detection.
  typedef struct packed {
    logic      valid;
    reg_addr_t dest;
  } ld_entry_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Signal bundle between the ID/WB stages (master) and the register scoreboard (slave).
// cnt_dbg exposes every pending counter so checkers can observe the tracked state.
interface reg_scoreboard_if
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = SCOREBOARD_CNT_LEN
);

  // issue_valid and wb_enable are single-cycle qualifiers with no ready/backpressure:
  // each is consumed on the rising edge where it is high and freeze is low, and the
  // only flow control back to ID is the combinational hazard stall request.
  logic                           issue_valid;
  reg_addr_t                      issue_dest;
  logic                           issue_is_load;
  reg_addr_t                      src1;
  logic                           src1_valid;
  reg_addr_t                      src2;
  logic                           two_src;
  logic                           wb_enable;
  reg_addr_t                      wb_dest;
  logic                           freeze;
  logic                           hazard;
  logic                           pending_any;
  logic                           overflow_err;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_dbg;

  modport master (
    output issue_valid, issue_dest, issue_is_load, src1, src1_valid,
           src2, two_src, wb_enable, wb_dest, freeze,
    input  hazard, pending_any, overflow_err, cnt_dbg
  );

  modport slave (
    input  issue_valid, issue_dest, issue_is_load, src1, src1_valid,
           src2, two_src, wb_enable, wb_dest, freeze,
    output hazard, pending_any, overflow_err, cnt_dbg
  );

endinterface

// File: rtl/reg_scoreboard_counter.sv
// Saturating up/down pending-write counter for a single architectural register.
// Simultaneous inc and dec cancel; decrement at zero is ignored.
module scoreboard_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign sat_o   = (cnt_q == CNT_MAX);

endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard beside the ID stage: counts outstanding writes per register
// and raises hazard for unresolved sources. Define SCOREBOARD_FORWARDING_EN for load-use only.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = SCOREBOARD_CNT_LEN
) (
  input logic               clk,
  input logic               rst,
  reg_scoreboard_if.slave   bus
);

  localparam int AW = REGFILE_ADDRESS_LEN;

  logic                           issue, retire;
  logic [NUM_REGS-1:0]            inc_oh, dec_oh, sat, nz_next;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic                           ovf_set;
  logic                           pending_any_q, pending_any_d;
  logic                           overflow_q, overflow_d;

  assign issue  = bus.issue_valid & ~bus.freeze;
  assign retire = bus.wb_enable & ~bus.freeze;

  always_comb begin
    inc_oh = '0;
    dec_oh = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_oh[r] = issue  && (bus.issue_dest == AW'(r));
      dec_oh[r] = retire && (bus.wb_dest    == AW'(r));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    scoreboard_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (inc_oh[g]),
      .dec_i   (dec_oh[g]),
      .count_o (cnt[g]),
      .sat_o   (sat[g])
    );
  end

  // Non-zero-ness of each counter's next value, without duplicating the counter datapath.
  always_comb begin
    nz_next = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      nz_next[r] = (inc_oh[r] & ~dec_oh[r]) |
                   ((cnt[r] != '0) & ~(dec_oh[r] & ~inc_oh[r] & (cnt[r] == CNT_W'(1))));
    end
  end

  assign ovf_set       = |(inc_oh & ~dec_oh & sat);
  assign pending_any_d = |nz_next;
  assign overflow_d    = overflow_q | ovf_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_any_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      pending_any_q <= pending_any_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.pending_any  = pending_any_q;
  assign bus.overflow_err = overflow_q;
  assign bus.cnt_dbg      = cnt;

`ifdef SCOREBOARD_FORWARDING_EN
  ld_entry_t ld_q, ld_d;

  always_comb begin
    ld_d = ld_q;
    if (!bus.freeze) begin
      ld_d.valid = issue & bus.issue_is_load;
      ld_d.dest  = bus.issue_dest;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_q <= '0;
    end else begin
      ld_q <= ld_d;
    end
  end

  assign bus.hazard = ld_q.valid &
                      ((bus.src1_valid & (bus.src1 == ld_q.dest)) |
                       (bus.two_src    & (bus.src2 == ld_q.dest)));
`else
  logic [NUM_REGS-1:0] eff_pend;

  // A write retiring this cycle lands in the regfile as ID reads it, so it no longer blocks;
  // a retire against an empty counter never produces a pending count.
  always_comb begin
    eff_pend = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      eff_pend[r] = (cnt[r] != '0) & ~(dec_oh[r] & (cnt[r] == CNT_W'(1)));
    end
  end

  assign bus.hazard = (bus.src1_valid & eff_pend[bus.src1]) |
                      (bus.two_src    & eff_pend[bus.src2]);
`endif

endmodule
